// File: rtl/mem_cl_responder.sv
// Single-outstanding cacheline memory responder: one 128-bit line per request,
// a programmable response delay, and backpressure-stable response fields.
module mem_cl_responder #(
    parameter int NLINES  = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  logic         memreq_type,
    input  logic [7:0]   memreq_opaque,
    input  logic [31:0]  memreq_addr,
    input  logic [127:0] memreq_data,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output logic         memresp_type,
    output logic [7:0]   memresp_opaque,
    output logic [127:0] memresp_data
);

    localparam int IDX_W = $clog2(NLINES);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic         typ;
        logic [7:0]   opaque;
        logic [127:0] data;
    } resp_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    resp_t            resp;
    logic [127:0]     mem [NLINES];
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             unused_addr;

    // Byte offset and bits above the index are dropped, so addresses wrap.
    assign idx         = memreq_addr[4 +: IDX_W];
    assign unused_addr = ^{memreq_addr[31:4+IDX_W], memreq_addr[3:0]};
    assign accept      = memreq_val && memreq_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        case (state)
            S_IDLE: begin
                memreq_rdy = 1'b1;
                if (memreq_val) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
            end
            S_RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter loads LATENCY-1 so the response lands LATENCY edges after accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          cnt <= 4'd0;
        else if (accept)                       cnt <= LAT_M1;
        else if (state == S_WAIT && cnt != 0)  cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp <= '0;
        end else if (accept) begin
            resp.typ    <= memreq_type;
            resp.opaque <= memreq_opaque;
            resp.data   <= memreq_type ? 128'd0 : mem[idx];
        end
    end

    // Backing store is deliberately not reset; a committed write survives reset.
    always_ff @(posedge clk) begin
        if (accept && memreq_type) mem[idx] <= memreq_data;
    end

    assign memresp_type   = resp.typ;
    assign memresp_opaque = resp.opaque;
    assign memresp_data   = resp.data;

endmodule

// File: doc/mem_cl_responder.md
MEM_CL_RESPONDER -- requirements
Module: mem_cl_responder

Interface
REQ-001 SHALL have parameter NLINES, default 64, giving the number of 128-bit cachelines in backing store; must be a power of 2 and at least 2.
REQ-002 SHALL have parameter LATENCY, default 2, giving extra response delay cycles; range 0-15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port memreq_val  input  1  request valid.
REQ-006 SHALL have port memreq_rdy  output  1  responder can accept a request.
REQ-007 SHALL have port memreq_type  input  1  0=read (refill), 1=write (evict).
REQ-008 SHALL have port memreq_opaque  input  8  tag echoed in the response.
REQ-009 SHALL have port memreq_addr  input  32 (abw)  byte address.
REQ-010 SHALL have port memreq_data  input  128 (clw)  write line.
REQ-011 SHALL have port memresp_val  output  1  response valid.
REQ-012 SHALL have port memresp_rdy  input  1  consumer accepts response.
REQ-013 SHALL have port memresp_type  output  1  echo of accepted memreq_type.
REQ-014 SHALL have port memresp_opaque  output  8  echo of accepted memreq_opaque.
REQ-015 SHALL have port memresp_data  output  128  read line; all zero for writes.

Function
REQ-016 SHALL implement a 3-state FSM: S_IDLE, S_WAIT, S_RESP.
REQ-017 SHALL drive memreq_rdy=1 only in S_IDLE; memresp_val=1 only in S_RESP.
REQ-018 SHALL accept a request on an edge where memreq_val && memreq_rdy. It SHALL latch type, opaque and line index = memreq_addr[4 +: log2(NLINES)].
- Address bits [3:0] SHALL be ignored.
- Address bits above the index SHALL be ignored, so addresses wrap modulo NLINES*16 bytes.
REQ-019 On acceptance with LATENCY=0, the FSM SHALL go S_IDLE->S_RESP. Otherwise it SHALL go S_IDLE->S_WAIT and load a 4-bit down-counter with LATENCY-1.
REQ-020 In S_WAIT, the counter SHALL decrement each cycle. On the edge where the counter is 0, the FSM SHALL go to S_RESP.
REQ-021 Timing: for a request accepted at edge T, memresp_val SHALL first be high in the cycle after edge T+LATENCY.
REQ-022 A write SHALL update the storage line at the acceptance edge. A read SHALL capture the line into the response register at the acceptance edge.
REQ-023 A read following a write to the same line SHALL return the newly written data.
REQ-024 memresp_type, memresp_opaque and memresp_data SHALL remain stable while memresp_val=1 && memresp_rdy=0, for any number of cycles.
REQ-025 On an edge where memresp_val && memresp_rdy, the FSM SHALL go S_RESP->S_IDLE. memreq_rdy SHALL be high in the next cycle.
REQ-026 At most one request SHALL be outstanding; there is no same-cycle response-accept/request-accept overlap.
REQ-027 memreq_val while memreq_rdy=0 SHALL have no effect; the requester must hold it.
REQ-028 memresp_rdy SHALL be ignored outside S_RESP.
REQ-029 Request inputs other than memreq_val SHALL be ignored when no handshake occurs.

Reset
REQ-030 While reset_n=0, outputs SHALL be: state=S_IDLE, counter=0, memreq_rdy=1, memresp_val=0, memresp_type=0, memresp_opaque=0, memresp_data=0.
REQ-031 Reset assertion mid-transaction (S_WAIT or S_RESP) SHALL abandon the transaction with no response.
- A write already accepted SHALL remain committed.
REQ-032 Storage contents SHALL NOT be reset; reads of never-written lines return undefined data and benches must write before reading.
REQ-033 The first request SHALL be accepted at the first rising edge after reset_n deasserts, if memreq_val=1.

Verification
REQ-034 Write/read, LATENCY=2: write addr 0x40 data 0x0123..CDEF opaque 0x11, then read addr 0x4C opaque 0x22 -> write response type=1 opaque 0x11 data 0 on the 3rd cycle after accept; read response type=0 opaque 0x22 data 0x0123..CDEF.
REQ-035 Wrap, NLINES=64: write addr 0x0000_0410 data 0xA5 repeated; read addr 0x10 -> data 0xA5 repeated.
REQ-036 Backpressure: memresp_rdy=0 for 5 cycles during a read response -> memresp_val held high with constant data and opaque; memreq_rdy=0 throughout; one handshake when rdy rises.
REQ-037 LATENCY=0, memresp_rdy tied 1, memreq_val tied 1 -> exactly one accept every 2 cycles; responses in order with matching opaques.
REQ-038 reset_n pulsed low while in S_WAIT after a write to line 3 -> no response; memreq_rdy=1 immediately; subsequent read of line 3 returns the written data.
